// File: rtl/secure_key_vault_pkg.sv
// -----------------------------------------------------------------------------
// secure_key_pkg
// Shared definitions for the secure key vault: request opcode encoding and the
// control state machine's state type.
// -----------------------------------------------------------------------------
package secure_key_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_LOCK    = 2'b10,
        OP_ZEROIZE = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ZERO = 1'b1
    } state_e;

endpackage

// File: rtl/secure_key_vault_key_slot_array.sv
// -----------------------------------------------------------------------------
// key_slot_array
// Key slot storage with per-slot sticky lock bits.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset (clears all slots
//                  and lock bits)
//   wr_en        : write wr_data into slot wr_slot
//   lock_en      : set the lock bit of slot wr_slot
//   clr_en       : clear slot wr_slot and its lock bit (overrides wr_en/lock_en)
//   wr_slot      : slot index for the single write/clear port
//   wr_data      : key value to write
//   rd_slot      : slot index for the single combinational read port
//   rd_data      : contents of rd_slot (zero if rd_slot is out of range)
//   rd_lock      : lock bit of rd_slot (zero if rd_slot is out of range)
//   lock_status  : all lock bits
// -----------------------------------------------------------------------------
module key_slot_array #(
    parameter  int KEY_W     = 32,
    parameter  int NUM_SLOTS = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 lock_en,
    input  logic                 clr_en,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [KEY_W-1:0]     wr_data,
    input  logic [SLOT_W-1:0]    rd_slot,
    output logic [KEY_W-1:0]     rd_data,
    output logic                 rd_lock,
    output logic [NUM_SLOTS-1:0] lock_status
);

    logic [KEY_W-1:0]     key_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] lock_q;

    // Key material is cleared on reset as well: a reset must never leave an
    // old key readable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                key_q[i] <= '0;
            end
            lock_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_slot == SLOT_W'(i)) begin
                    if (clr_en) begin
                        key_q[i]  <= '0;
                        lock_q[i] <= 1'b0;
                    end else begin
                        if (wr_en) begin
                            key_q[i] <= wr_data;
                        end
                        if (lock_en) begin
                            lock_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Indices past NUM_SLOTS-1 match no slot and read back as zero.
    always_comb begin
        rd_data = '0;
        rd_lock = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_slot == SLOT_W'(i)) begin
                rd_data = key_q[i];
                rd_lock = lock_q[i];
            end
        end
    end

    assign lock_status = lock_q;

endmodule

// File: rtl/secure_key_vault.sv
// -----------------------------------------------------------------------------
// secure_key_vault
// Access-controlled multi-slot key store. Requests (READ/WRITE/LOCK/ZEROIZE)
// are accepted one per cycle in IDLE and answered with a one-cycle response
// pulse on the next cycle. ZEROIZE walks every slot, clearing key and lock,
// then responds. Key data only leaves on rsp_data for a successful READ.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : request present
//   req_ready    : high in IDLE; request accepted when req_valid && req_ready
//   req_op       : 00 READ, 01 WRITE, 10 LOCK, 11 ZEROIZE
//   req_slot     : target slot (ignored for ZEROIZE)
//   req_secure   : requester privilege, 1 = secure
//   req_wdata    : key value for WRITE
//   rsp_valid    : one-cycle response pulse
//   rsp_err      : request rejected (qualified by rsp_valid)
//   rsp_data     : READ data, zero unless a successful READ response
//   lock_status  : per-slot sticky lock bits
//   busy         : zeroize in progress
// -----------------------------------------------------------------------------
module secure_key_vault
    import secure_key_pkg::*;
#(
    parameter  int KEY_W     = 32,
    parameter  int NUM_SLOTS = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [SLOT_W-1:0]    req_slot,
    input  logic                 req_secure,
    input  logic [KEY_W-1:0]     req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [KEY_W-1:0]     rsp_data,
    output logic [NUM_SLOTS-1:0] lock_status,
    output logic                 busy
);

    localparam logic [SLOT_W:0]   SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] zc_q, zc_d;

    logic              rsp_valid_p1, rsp_valid_d;
    logic              rsp_err_p1, rsp_err_d;
    logic [KEY_W-1:0]  rsp_data_p1, rsp_data_d;

    logic              arr_wr_en, arr_lock_en, arr_clr_en;
    logic [SLOT_W-1:0] arr_slot;
    logic [KEY_W-1:0]  rd_data;
    logic              rd_lock;

    op_e               op;
    logic              slot_oob;
    logic              req_err;

    key_slot_array #(
        .KEY_W     (KEY_W),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slots (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (arr_wr_en),
        .lock_en     (arr_lock_en),
        .clr_en      (arr_clr_en),
        .wr_slot     (arr_slot),
        .wr_data     (req_wdata),
        .rd_slot     (req_slot),
        .rd_data     (rd_data),
        .rd_lock     (rd_lock),
        .lock_status (lock_status)
    );

    // Access check. ZEROIZE ignores the slot field, so only privilege matters.
    // rd_lock reads as zero for an out-of-range slot, which is already an error.
    assign op       = op_e'(req_op);
    assign slot_oob = ({1'b0, req_slot} >= SLOT_LIMIT);
    assign req_err  = !req_secure
                    || ((op != OP_ZEROIZE) && slot_oob)
                    || ((op == OP_WRITE) && rd_lock);

    always_comb begin
        state_d     = state_q;
        zc_d        = zc_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        arr_wr_en   = 1'b0;
        arr_lock_en = 1'b0;
        arr_clr_en  = 1'b0;
        arr_slot    = req_slot;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    if (req_err) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        case (op)
                            OP_READ:  rsp_data_d  = rd_data;
                            OP_WRITE: arr_wr_en   = 1'b1;
                            OP_LOCK:  arr_lock_en = 1'b1;
                            OP_ZEROIZE: begin
                                // Response is deferred until the last slot is cleared.
                                rsp_valid_d = 1'b0;
                                state_d     = ST_ZERO;
                                zc_d        = '0;
                            end
                        endcase
                    end
                end
            end
            ST_ZERO: begin
                arr_clr_en = 1'b1;
                arr_slot   = zc_q;
                zc_d       = zc_q + 1'b1;
                if (zc_q == LAST_SLOT) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response register stage (_p1): visible the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            zc_q         <= '0;
            rsp_valid_p1 <= 1'b0;
            rsp_err_p1   <= 1'b0;
            rsp_data_p1  <= '0;
        end else begin
            state_q      <= state_d;
            zc_q         <= zc_d;
            rsp_valid_p1 <= rsp_valid_d;
            rsp_err_p1   <= rsp_err_d;
            rsp_data_p1  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ZERO);
    assign rsp_valid = rsp_valid_p1;
    assign rsp_err   = rsp_err_p1;
    assign rsp_data  = rsp_data_p1;

endmodule

// File: doc/secure_key_vault.md
# secure_key_vault

Multi-slot, access-controlled key store, the parametrised successor to the team's single-register key storage block. It holds NUM_SLOTS keys of KEY_W bits behind a request/response interface. Writes, reads, per-slot sticky locks and a full zeroize sequence are all gated by a privilege bit. It sits between the SoC control fabric and the crypto engines, and key material is never returned to a non-secure requester.

## Interface
- KEY_W, 32, key width in bits (≥ 8)
- NUM_SLOTS, 4, number of key slots (2..16; need not be a power of two)
- SLOT_W, $clog2(NUM_SLOTS), slot index width (derived; do not override)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  2  00 READ, 01 WRITE, 10 LOCK, 11 ZEROIZE
- req_slot  in  SLOT_W  target slot; ignored for ZEROIZE
- req_secure  in  1  requester privilege, 1 = secure
- req_wdata  in  KEY_W  key value for WRITE
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_err  out  1  request rejected; valid only with rsp_valid
- rsp_data  out  KEY_W  READ data; zero unless a successful READ response
- lock_status  out  NUM_SLOTS  per-slot sticky lock bits
- busy  out  1  zeroize in progress

## Operation
- State machine has two states: IDLE and ZERO.
- req_ready = (state == IDLE). A request is accepted on a cycle where req_valid && req_ready.
- An error occurs when any of the following is true:
  - req_secure == 0 (every op), or
  - req_slot ≥ NUM_SLOTS (READ, WRITE, LOCK), or
  - WRITE to a slot whose lock bit is set.
- On error: no state changes, rsp_err = 1, rsp_data = 0.
- READ: returns the slot contents on rsp_data.
- WRITE: slot ← req_wdata.
- LOCK: sets lock_status[slot]. Lock bits are sticky and are cleared only by ZEROIZE or rst. Locking an already-locked slot succeeds with no change.
- ZEROIZE (secure only): IDLE → ZERO, with counter zc = 0.
  - Each ZERO cycle clears slot zc and its lock bit, then increments zc.
  - After slot NUM_SLOTS-1 is cleared, the block returns to IDLE and pulses rsp_valid with rsp_err = 0.
  - A non-secure ZEROIZE is rejected like any other error and does not enter ZERO.
- busy = (state == ZERO).
- Keys are never observable on any output except rsp_data in a successful READ response.

## Timing
- Reset: all slots = 0, lock_status = 0, rsp_valid = 0, rsp_err = 0, rsp_data = 0, state = IDLE, busy = 0, req_ready = 1 from the first cycle after rst deasserts.
- READ / WRITE / LOCK accepted in cycle N → response in cycle N+1. Full throughput: one request per cycle in IDLE.
- WRITE then READ of the same slot in back-to-back cycles: the READ returns the new value (the write commits at the end of cycle N).
- ZEROIZE accepted in cycle N:
  - Slots are cleared at the ends of cycles N+1 … N+NUM_SLOTS.
  - busy is high and req_ready low during N+1 … N+NUM_SLOTS.
  - rsp_valid is high in cycle N+NUM_SLOTS+1 and req_ready returns in the same cycle.
- rst mid-zeroize: everything returns to reset values on the next edge and no response is issued.
- rst has priority over any request accepted in the same cycle.

## Structure
- The shared package secure_key_pkg holds the op encoding (OP_READ, OP_WRITE, OP_LOCK, OP_ZEROIZE) and the state enum (ST_IDLE, ST_ZERO).
- One sub-module, key_slot_array: slot storage plus lock bits, with a single write/clear port and a single read port. The FSM, access checks and response register stay in the top level.

## Test plan
- Reset, then secure WRITE slot 2 = 0xDEADBEEF, then READ slot 2 → rsp_valid at N+1, rsp_data = 0xDEADBEEF, rsp_err = 0.
- Non-secure READ of slot 2 → rsp_err = 1, rsp_data = 0. Non-secure WRITE 0x1 → slot still reads 0xDEADBEEF on a later secure READ.
- LOCK slot 2, then secure WRITE 0x12345678 → rsp_err = 1, lock_status = 4'b0100, READ still returns 0xDEADBEEF.
- With NUM_SLOTS = 3, READ slot 3 → rsp_err = 1.
- Fill all slots, lock slot 0, then ZEROIZE:
  - busy is high for exactly NUM_SLOTS cycles and req_ready is low throughout;
  - requests offered during busy are not accepted;
  - the response arrives at N+NUM_SLOTS+1;
  - afterwards every slot reads 0, lock_status = 0, and a WRITE to slot 0 succeeds.
- Assert rst two cycles into a ZEROIZE → no rsp_valid, all outputs at reset values, req_ready = 1 on the next cycle.
